mini_src_control_sequencer: RTL and testbench
=============================================

// Module: mini_src_control_sequencer
// PURPOSE
//  Hardwired control sequencer for the Mini-SRC datapath. Steps through T0..T6
//  per instruction and drives every datapath strobe: PC, MAR, MDR, IR, Y, Z, HI/LO, R0-R15 in/out, ALU opcode.
//  Fetches, decodes IR, and sequences 3-register ALU, mul/div and neg/not ops.
//  Handles halt and illegal opcodes. Sits directly upstream of Datapath.
// PARAMETERS
//  MEM_TIMEOUT  15        max T1 wait cycles for mem_ready before FAULT (1..255)
//  HALT_OPC     5'b11011  opcode that enters HALT
// PORTS
//  clock      in   1   system clock, all state updates on posedge
//  clear      in   1   asynchronous, active-low reset
//  run        in   1   level; leave IDLE and begin fetching while high
//  mem_ready  in   1   memory data valid on Mdatain this cycle
//  ir         in   32  datapath IR contents; valid from T3 onward
//  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin  out 1  datapath strobes
//  Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin             out 1  datapath strobes
//  R_in       out  16  one-hot register write enable (R0..R15)
//  R_out      out  16  one-hot register bus drive (R0..R15)
//  alu_op     out  5   ALU opcode to Datapath.opcode
//  halted     out  1   high while in HALT
//  fault      out  1   high while in FAULT
// BEHAVIOUR
//  - Moore outputs: every output is a pure decode of the state register and ir.
//    No output depends combinationally on run or mem_ready.
//  - clear low: state goes to IDLE immediately, wait counter goes to 0, all outputs 0.
//    This holds mid-instruction too; no partial strobe survives.
//  - Fields: op=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
//  - Op classes:
//      R3 (3-reg ALU): 00011..01011
//      MD (mul/div): 10000 mul, 01111 div
//      U2 (neg/not): 10001 neg, 10010 not
//      HALT_OPC
//      anything else is illegal.
//  - alu_op = op in T3 (U2 only) and T4; 5'b00000 in every other state.
//  - IDLE: all outputs 0. Goes to T0 when run=1.
//  - T0: PCout, MARin, IncPC, Zlowin (PC+1 into Z). Next state T1.
//  - T1: Zlowout, PCin, Read, MDRin.
//    Held while mem_ready=0; re-asserting PCin is harmless because Z is unchanged.
//    Goes to T2 on mem_ready=1.
//    Wait counter increments each held cycle; a count reaching MEM_TIMEOUT goes to FAULT.
//  - T2: MDRout, IRin. Next state T3.
//  - T3, decode on ir:
//      R3/MD: R_out=1<<Rb (R3) or 1<<Ra (MD), Yin. Next state T4.
//      U2:    R_out=1<<Rb, Zlowin. Next state T4.
//      HALT_OPC: no strobes. Next state HALT.
//      illegal:  no strobes. Next state FAULT.
//  - T4:
//      R3: R_out=1<<Rc, Zlowin. Next state T5.
//      MD: R_out=1<<Rb, Zlowin, Zhighin. Next state T5.
//      U2: Zlowout, R_in=1<<Ra. Next state T0 if run else IDLE.
//  - T5:
//      R3: Zlowout, R_in=1<<Ra. Next state T0/IDLE.
//      MD: Zlowout, LOin. Next state T6.
//  - T6 (MD only): Zhighout, HIin. Next state T0/IDLE.
//  - Latency with no memory wait: R3 = 6 cycles, MD = 7, U2 = 5. Each mem wait cycle adds 1.
//  - run is sampled only in IDLE and at instruction end.
//    Dropping run mid-instruction completes that instruction, then returns to IDLE.
//  - HALT and FAULT are sticky until clear. halted=1 in HALT, fault=1 in FAULT, all other outputs 0.
//  - Invariants (assertion-checked):
//      at most one bus driver (PCout, MDRout, Zlowout, Zhighout, any R_out bit) per cycle;
//      R_in and R_out are always zero or one-hot.
//  - R0 is treated like any other register; R0 semantics belong to Datapath.
// TESTING
//  1. or R1,R2,R3: ir=0x28918000, mem_ready=1, run=1
//     -> T0..T5 in 6 cycles; T3 R_out=0x0004 Yin;
//        T4 R_out=0x0008 alu_op=00101 Zlowin; T5 Zlowout R_in=0x0002;
//        T0 again in cycle 7.
//  2. sub: ir=0x20918000 with mem_ready low 3 cycles in T1
//     -> T1 held 4 cycles with Read=MDRin=1 throughout; IRin only in T2;
//        T4 alu_op=00100.
//  3. mul R2,R3: ir=0x81180000
//     -> T4 R_out=0x0008 Zlowin=Zhighin=1 alu_op=10000;
//        T5 Zlowout LOin; T6 Zhighout HIin; 7 cycles total.
//  4. not R1,R2: ir=0x90900000
//     -> T3 R_out=0x0004 Zlowin alu_op=10010; T4 Zlowout R_in=0x0002;
//        T0 in cycle 6.
//  5. halt ir=0xD8000000 -> halted=1 after T3, no T0 despite run=1.
//     illegal ir=0xF8000000 -> fault=1.
//     mem_ready held low 16 cycles -> fault=1.
//  6. clear pulsed low mid-T4 -> all outputs 0 in the same cycle, state IDLE;
//     after release with run=1 -> PCout and MARin one cycle later.

Source files
------------

// File: rtl/mini_src_control_sequencer_if.sv
// Control interface between the Mini-SRC sequencer and its datapath:
// status inputs to the sequencer plus every strobe it drives.
interface mini_src_control_sequencer_if;
  logic        run;
  logic        mem_ready;
  logic [31:0] ir;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic        Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
  logic [15:0] R_in;
  logic [15:0] R_out;
  logic [4:0]  alu_op;
  logic        halted;
  logic        fault;

  modport master (
    input  run, mem_ready, ir,
    output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
    output Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
    output R_in, R_out, alu_op, halted, fault
  );

  modport slave (
    output run, mem_ready, ir,
    input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
    input  Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
    input  R_in, R_out, alu_op, halted, fault
  );
endinterface

// File: rtl/mini_src_control_sequencer.sv
// Hardwired T0..T6 control sequencer for the Mini-SRC datapath.
// All outputs are a Moore decode of the state register and ir.
module mini_src_control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [4:0]  HALT_OPC    = 5'b11011
) (
  input logic                          clock,
  input logic                          clear,
  mini_src_control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT, S_FAULT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, next_state;
  logic [7:0] wait_cnt;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_r3, is_md, is_u2, is_halt;
  logic       unused_ir;

  assign op        = bus.ir[31:27];
  assign ra        = bus.ir[26:23];
  assign rb        = bus.ir[22:19];
  assign rc        = bus.ir[18:15];
  assign unused_ir = ^bus.ir[14:0];

  assign is_r3   = (op >= 5'd3) && (op <= 5'd11);
  assign is_md   = (op == 5'b10000) || (op == 5'b01111);
  assign is_u2   = (op == 5'b10001) || (op == 5'b10010);
  assign is_halt = (op == HALT_OPC);

  function automatic logic [15:0] dec(input logic [3:0] n);
    return 16'h0001 << n;
  endfunction

  logic        pc_out, mar_in, inc_pc, pc_in, rd, mdr_in, mdr_out, ir_in, y_in;
  logic        zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in;
  logic [15:0] r_in, r_out;
  logic [4:0]  alu;
  logic        halted_o, fault_o;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      // Counter only runs while T1 is being held for memory.
      if (state == S_T1 && !bus.mem_ready) wait_cnt <= wait_cnt + 8'd1;
      else                                 wait_cnt <= '0;
    end
  end

  always_comb begin
    next_state = state;
    pc_out = 1'b0; mar_in = 1'b0; inc_pc = 1'b0; pc_in = 1'b0; rd = 1'b0;
    mdr_in = 1'b0; mdr_out = 1'b0; ir_in = 1'b0; y_in = 1'b0;
    zlow_in = 1'b0; zhigh_in = 1'b0; zlow_out = 1'b0; zhigh_out = 1'b0;
    hi_in = 1'b0; lo_in = 1'b0;
    r_in = '0; r_out = '0; alu = '0;
    halted_o = 1'b0; fault_o = 1'b0;

    case (state)
      S_IDLE: if (bus.run) next_state = S_T0;
      S_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; zlow_in = 1'b1;
        next_state = S_T1;
      end
      S_T1: begin
        zlow_out = 1'b1; pc_in = 1'b1; rd = 1'b1; mdr_in = 1'b1;
        if (bus.mem_ready)           next_state = S_T2;
        else if (wait_cnt == WAIT_LAST) next_state = S_FAULT;
      end
      S_T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
        next_state = S_T3;
      end
      S_T3: begin
        if (is_r3) begin
          r_out = dec(rb); y_in = 1'b1; next_state = S_T4;
        end else if (is_md) begin
          r_out = dec(ra); y_in = 1'b1; next_state = S_T4;
        end else if (is_u2) begin
          r_out = dec(rb); zlow_in = 1'b1; alu = op; next_state = S_T4;
        end else if (is_halt) begin
          next_state = S_HALT;
        end else begin
          next_state = S_FAULT;
        end
      end
      S_T4: begin
        alu = op;
        if (is_r3) begin
          r_out = dec(rc); zlow_in = 1'b1; next_state = S_T5;
        end else if (is_md) begin
          r_out = dec(rb); zlow_in = 1'b1; zhigh_in = 1'b1; next_state = S_T5;
        end else begin
          zlow_out = 1'b1; r_in = dec(ra);
          next_state = bus.run ? S_T0 : S_IDLE;
        end
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (is_md) begin
          lo_in = 1'b1; next_state = S_T6;
        end else begin
          r_in = dec(ra); next_state = bus.run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        zhigh_out = 1'b1; hi_in = 1'b1;
        next_state = bus.run ? S_T0 : S_IDLE;
      end
      S_HALT:  halted_o = 1'b1;
      S_FAULT: fault_o  = 1'b1;
      default: next_state = S_IDLE;
    endcase
  end

  assign bus.PCout    = pc_out;
  assign bus.MARin    = mar_in;
  assign bus.IncPC    = inc_pc;
  assign bus.PCin     = pc_in;
  assign bus.Read     = rd;
  assign bus.MDRin    = mdr_in;
  assign bus.MDRout   = mdr_out;
  assign bus.IRin     = ir_in;
  assign bus.Yin      = y_in;
  assign bus.Zlowin   = zlow_in;
  assign bus.Zhighin  = zhigh_in;
  assign bus.Zlowout  = zlow_out;
  assign bus.Zhighout = zhigh_out;
  assign bus.HIin     = hi_in;
  assign bus.LOin     = lo_in;
  assign bus.R_in     = r_in;
  assign bus.R_out    = r_out;
  assign bus.alu_op   = alu;
  assign bus.halted   = halted_o;
  assign bus.fault    = fault_o;

  always_ff @(posedge clock) begin
    if (clear) begin
      assert ($countones({pc_out, mdr_out, zlow_out, zhigh_out, r_out}) <= 1);
      assert ($onehot0(r_in));
      assert ($onehot0(r_out));
    end
  end

endmodule

// File: tb/tb_mini_src_control_sequencer.sv
// Directed scoreboard bench for mini_src_control_sequencer: expected per-cycle
// outputs are queued with their stimulus and compared at each falling edge.
module tb_mini_src_control_sequencer;

  localparam int unsigned TIMEOUT = 15;

  logic clock;
  logic clear;

  mini_src_control_sequencer_if bus ();

  mini_src_control_sequencer #(.MEM_TIMEOUT(TIMEOUT), .HALT_OPC(5'b11011)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        pc_out, mar_in, inc_pc, pc_in, rd, mdr_in, mdr_out, ir_in, y_in;
    logic        zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in;
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic [4:0]  alu;
    logic        halted, fault;
  } outs_t;

  typedef struct {
    string       tag;
    logic [31:0] ir;
    logic        run;
    logic        mr;
    logic        clr;
    outs_t       exp;
  } item_t;

  item_t q[$];
  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  function automatic outs_t observe();
    outs_t o;
    o.pc_out = bus.PCout;   o.mar_in = bus.MARin;    o.inc_pc = bus.IncPC;
    o.pc_in = bus.PCin;     o.rd = bus.Read;         o.mdr_in = bus.MDRin;
    o.mdr_out = bus.MDRout; o.ir_in = bus.IRin;      o.y_in = bus.Yin;
    o.zlow_in = bus.Zlowin; o.zhigh_in = bus.Zhighin;
    o.zlow_out = bus.Zlowout; o.zhigh_out = bus.Zhighout;
    o.hi_in = bus.HIin;     o.lo_in = bus.LOin;
    o.r_in = bus.R_in;      o.r_out = bus.R_out;     o.alu = bus.alu_op;
    o.halted = bus.halted;  o.fault = bus.fault;
    return o;
  endfunction

  task automatic check(input string tag, input outs_t exp);
    outs_t obs;
    obs = observe();
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void push(input string tag, input logic [31:0] irv,
                               input logic rn, input logic mr, input logic clr,
                               input outs_t e);
    item_t it;
    it.tag = tag; it.ir = irv; it.run = rn; it.mr = mr; it.clr = clr; it.exp = e;
    q.push_back(it);
  endfunction

  function automatic void push_flat(input string tag, input int unsigned n,
                                    input logic rn, input logic clr,
                                    input logic hlt, input logic flt);
    outs_t e;
    e = '0; e.halted = hlt; e.fault = flt;
    for (int unsigned i = 0; i < n; i++) push(tag, 32'h0, rn, 1'b1, clr, e);
  endfunction

  // Expected per-cycle outputs of one instruction, derived from the op class table.
  function automatic void push_instr(input string nm, input logic [31:0] irv,
                                     input int unsigned waits, input logic rn);
    outs_t e;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = irv[31:27]; ra = irv[26:23]; rb = irv[22:19]; rc = irv[18:15];
    e = '0; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.zlow_in = 1;
    push({nm, ".T0"}, irv, rn, 1'b1, 1'b1, e);
    for (int unsigned i = 0; i <= waits; i++) begin
      e = '0; e.zlow_out = 1; e.pc_in = 1; e.rd = 1; e.mdr_in = 1;
      push($sformatf("%s.T1w%0d", nm, i), irv, rn, (i == waits), 1'b1, e);
    end
    e = '0; e.mdr_out = 1; e.ir_in = 1;
    push({nm, ".T2"}, irv, rn, 1'b1, 1'b1, e);
    if (op inside {[5'd3:5'd11]}) begin
      e = '0; e.r_out = 16'h1 << rb; e.y_in = 1;
      push({nm, ".T3"}, irv, rn, 1'b1, 1'b1, e);
      e = '0; e.r_out = 16'h1 << rc; e.zlow_in = 1; e.alu = op;
      push({nm, ".T4"}, irv, rn, 1'b1, 1'b1, e);
      e = '0; e.zlow_out = 1; e.r_in = 16'h1 << ra;
      push({nm, ".T5"}, irv, rn, 1'b1, 1'b1, e);
    end else if (op == 5'b10000 || op == 5'b01111) begin
      e = '0; e.r_out = 16'h1 << ra; e.y_in = 1;
      push({nm, ".T3"}, irv, rn, 1'b1, 1'b1, e);
      e = '0; e.r_out = 16'h1 << rb; e.zlow_in = 1; e.zhigh_in = 1; e.alu = op;
      push({nm, ".T4"}, irv, rn, 1'b1, 1'b1, e);
      e = '0; e.zlow_out = 1; e.lo_in = 1;
      push({nm, ".T5"}, irv, rn, 1'b1, 1'b1, e);
      e = '0; e.zhigh_out = 1; e.hi_in = 1;
      push({nm, ".T6"}, irv, rn, 1'b1, 1'b1, e);
    end else if (op == 5'b10001 || op == 5'b10010) begin
      e = '0; e.r_out = 16'h1 << rb; e.zlow_in = 1; e.alu = op;
      push({nm, ".T3"}, irv, rn, 1'b1, 1'b1, e);
      e = '0; e.zlow_out = 1; e.r_in = 16'h1 << ra; e.alu = op;
      push({nm, ".T4"}, irv, rn, 1'b1, 1'b1, e);
    end else begin
      e = '0;
      push({nm, ".T3"}, irv, rn, 1'b1, 1'b1, e);
    end
  endfunction

  task automatic run_items(input int unsigned n);
    item_t it;
    for (int unsigned k = 0; k < n && q.size() > 0; k++) begin
      it = q.pop_front();
      @(negedge clock);
      bus.ir = it.ir; bus.run = it.run; bus.mem_ready = it.mr; clear = it.clr;
      #1;
      check(it.tag, it.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t e;
    item_t it;
    clear = 1'b0; bus.run = 1'b0; bus.mem_ready = 1'b0; bus.ir = '0;

    push_flat("reset", 2, 1'b0, 1'b0, 1'b0, 1'b0);
    push_flat("idle_release", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    push_instr("or", 32'h28918000, 0, 1'b1);
    push_instr("sub_w3", 32'h20918000, 3, 1'b1);
    push_instr("mul", 32'h81180000, 0, 1'b1);
    push_instr("not", 32'h90900000, 0, 1'b1);
    push_instr("or_w14", 32'h28918000, TIMEOUT - 1, 1'b1);
    push_instr("or_rundrop", 32'h28918000, 0, 1'b0);
    push_flat("idle_norun", 2, 1'b0, 1'b1, 1'b0, 1'b0);
    push_flat("idle_run", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    push_instr("halt", 32'hD8000000, 0, 1'b1);
    push_flat("halted", 3, 1'b1, 1'b1, 1'b1, 1'b0);
    push_flat("clr_halt", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    push_flat("rel_halt", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    push_instr("illegal", 32'hF8000000, 0, 1'b1);
    push_flat("faulted", 2, 1'b1, 1'b1, 1'b0, 1'b1);
    push_flat("clr_fault", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    push_flat("rel_fault", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    e = '0; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.zlow_in = 1;
    push("tmo.T0", 32'h28918000, 1'b1, 1'b0, 1'b1, e);
    for (int unsigned i = 0; i < TIMEOUT; i++) begin
      e = '0; e.zlow_out = 1; e.pc_in = 1; e.rd = 1; e.mdr_in = 1;
      push($sformatf("tmo.T1w%0d", i), 32'h28918000, 1'b1, 1'b0, 1'b1, e);
    end
    push_flat("tmo_fault", 2, 1'b1, 1'b1, 1'b0, 1'b1);
    push_flat("clr_tmo", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    push_flat("rel_tmo", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_items(q.size());

    // Clear asserted in the middle of T4 must blank every strobe at once.
    push_instr("mul_clr", 32'h81180000, 0, 1'b1);
    run_items(5);
    #2;
    clear = 1'b0;
    #1;
    check("clear_midT4", '0);
    q.delete();
    @(negedge clock);
    clear = 1'b1; bus.run = 1'b1;
    #1;
    check("clear_release_idle", '0);
    push_instr("or_after_clr", 32'h28918000, 0, 1'b1);
    run_items(1);
    q.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
